hazard_unit: RTL and testbench



---
 rtl/hazard_unit_if.sv | 40 ++++
 rtl/hazard_unit.sv | 121 ++++++++++++
 tb/tb_hazard_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// +---------------------------------------------------------------------------+
// | hazard_unit_if : pipeline-register taps and hazard controls               |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1_D, Rs2_D;
  logic [4:0]       Rs1_E, Rs2_E, Rd_E;
  logic             RegWrite_E;
  logic [1:0]       ResultSrc_E;
  logic             PCSrc_E;
  logic [4:0]       Rd_M;
  logic             RegWrite_M;
  logic [4:0]       Rd_W;
  logic             RegWrite_W;
  logic             mem_busy;
  logic             Stall_F, Stall_D, Stall_E, Stall_M;
  logic             Flush_D, Flush_E;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, RegWrite_E, ResultSrc_E, PCSrc_E,
           Rd_M, RegWrite_M, Rd_W, RegWrite_W, mem_busy,
    input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
           ForwardA_E, ForwardB_E, stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, RegWrite_E, ResultSrc_E, PCSrc_E,
           Rd_M, RegWrite_M, Rd_W, RegWrite_W, mem_busy,
    output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
           ForwardA_E, ForwardB_E, stall_cnt, flush_cnt, wait_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
// +---------------------------------------------------------------------------+
// | hazard_unit : stall/flush/forward control for the five-stage RV64I core   |
// | Optional: HAZARD_PERF_CNT_EN enables saturating performance counters.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module hazard_unit #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  hazard_unit_if.slave hz
);

  localparam logic [2:0] c_RELOAD = 3'(REDIRECT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t     r_state, w_state_next;
  logic [2:0] r_redir_cnt, w_redir_cnt_next;
  logic       w_lw_stall;
  logic       w_freeze, w_stall_fd, w_flush_d, w_flush_e, w_lw_bubble;

  // Memory stage wins over Writeback; x0 is hardwired and never forwarded.
  assign hz.ForwardA_E = (hz.RegWrite_M && hz.Rd_M != 5'd0 && hz.Rd_M == hz.Rs1_E) ? 2'b10 :
                         (hz.RegWrite_W && hz.Rd_W != 5'd0 && hz.Rd_W == hz.Rs1_E) ? 2'b01 : 2'b00;
  assign hz.ForwardB_E = (hz.RegWrite_M && hz.Rd_M != 5'd0 && hz.Rd_M == hz.Rs2_E) ? 2'b10 :
                         (hz.RegWrite_W && hz.Rd_W != 5'd0 && hz.Rd_W == hz.Rs2_E) ? 2'b01 : 2'b00;

  assign w_lw_stall = hz.RegWrite_E && hz.ResultSrc_E == 2'b01 && hz.Rd_E != 5'd0 &&
                      (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_redir_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_redir_cnt <= w_redir_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_redir_cnt_next = r_redir_cnt;
    w_freeze         = 1'b0;
    w_stall_fd       = 1'b0;
    w_flush_d        = 1'b0;
    w_flush_e        = 1'b0;
    w_lw_bubble      = 1'b0;
    if (hz.mem_busy) begin
      // A freeze inside REDIRECT keeps both the state and the countdown.
      w_freeze = 1'b1;
      if (r_state != REDIRECT) w_state_next = MEM_WAIT;
    end else if (r_state == REDIRECT) begin
      w_flush_d = 1'b1;
      if (hz.PCSrc_E) begin
        w_flush_e        = 1'b1;
        w_redir_cnt_next = c_RELOAD;
      end else begin
        w_redir_cnt_next = r_redir_cnt - 3'd1;
        if (r_redir_cnt <= 3'd1) w_state_next = RUN;
      end
    end else begin
      w_state_next = RUN;
      if (hz.PCSrc_E) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
        if (REDIRECT_CYCLES > 1) begin
          w_state_next     = REDIRECT;
          w_redir_cnt_next = c_RELOAD;
        end
      end else if (w_lw_stall) begin
        w_stall_fd  = 1'b1;
        w_flush_e   = 1'b1;
        w_lw_bubble = 1'b1;
      end
    end
  end

  // Controls are forced low while reset is asserted, regardless of inputs.
  assign hz.Stall_F = rst_n & (w_freeze | w_stall_fd);
  assign hz.Stall_D = rst_n & (w_freeze | w_stall_fd);
  assign hz.Stall_E = rst_n & w_freeze;
  assign hz.Stall_M = rst_n & w_freeze;
  assign hz.Flush_D = rst_n & w_flush_d;
  assign hz.Flush_E = rst_n & w_flush_e;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_lw_bubble && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_d   && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_freeze    && r_wait_cnt  != '1) r_wait_cnt  <= r_wait_cnt  + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
  assign hz.wait_cnt  = r_wait_cnt;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
  assign hz.wait_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// +---------------------------------------------------------------------------+
// | tb_hazard_unit : directed self-checking bench for hazard_unit             |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(32)) hz ();

  hazard_unit #(
    .REDIRECT_CYCLES(3),
    .CNT_W          (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz.slave)
  );

  // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}
  logic [5:0] ctrl;
  assign ctrl = {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Stall_M, hz.Flush_D, hz.Flush_E};

  task automatic idle_inputs();
    hz.Rs1_D = 0; hz.Rs2_D = 0; hz.Rs1_E = 0; hz.Rs2_E = 0; hz.Rd_E = 0;
    hz.RegWrite_E = 0; hz.ResultSrc_E = 0; hz.PCSrc_E = 0;
    hz.Rd_M = 0; hz.RegWrite_M = 0; hz.Rd_W = 0; hz.RegWrite_W = 0; hz.mem_busy = 0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    hz.mem_busy = 1;
    hz.PCSrc_E  = 1;
    next_cycle(); #1;
    if (ctrl !== 6'b000000) begin errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 6'b000000); end
    checks++;
    if ({hz.stall_cnt, hz.flush_cnt, hz.wait_cnt} !== 96'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", hz.stall_cnt, hz.flush_cnt, hz.wait_cnt);
    end
    checks++;
    idle_inputs();
    rst_n = 1'b1;
    next_cycle(); #1;
    if (ctrl !== 6'b000000) begin errors++; $display("FAIL run_idle: got %b want %b", ctrl, 6'b000000); end
    checks++;
  endtask

  task automatic test_load_use();
    idle_inputs();
    next_cycle();
    hz.RegWrite_E = 1; hz.ResultSrc_E = 2'b01; hz.Rd_E = 5; hz.Rs1_D = 5;
    #1;
    if (ctrl !== 6'b110001) begin errors++; $display("FAIL lu_bubble: got %b want %b", ctrl, 6'b110001); end
    checks++;
    next_cycle();
    idle_inputs();
    hz.Rd_M = 5; hz.RegWrite_M = 1; hz.Rs1_D = 5;
    #1;
    if (ctrl !== 6'b000000) begin errors++; $display("FAIL lu_release: got %b want %b", ctrl, 6'b000000); end
    checks++;
    if (hz.stall_cnt !== 32'(PERF)) begin errors++; $display("FAIL lu_stall_cnt: got %0d want %0d", hz.stall_cnt, PERF); end
    checks++;
    next_cycle();
    idle_inputs();
    hz.Rd_W = 5; hz.RegWrite_W = 1; hz.Rs1_E = 5;
    #1;
    if (hz.ForwardA_E !== 2'b01) begin errors++; $display("FAIL lu_fwdA: got %b want %b", hz.ForwardA_E, 2'b01); end
    checks++;
    // x0 load never stalls
    next_cycle();
    idle_inputs();
    hz.RegWrite_E = 1; hz.ResultSrc_E = 2'b01; hz.Rd_E = 0; hz.Rs2_D = 0;
    #1;
    if (ctrl !== 6'b000000) begin errors++; $display("FAIL lu_x0: got %b want %b", ctrl, 6'b000000); end
    checks++;
  endtask

  task automatic test_forwarding();
    next_cycle();
    idle_inputs();
    hz.Rd_M = 7; hz.RegWrite_M = 1; hz.Rd_W = 7; hz.RegWrite_W = 1; hz.Rs2_E = 7; hz.Rs1_E = 3;
    #1;
    if ({hz.ForwardA_E, hz.ForwardB_E} !== 4'b0010) begin
      errors++; $display("FAIL fwd_mem_prio: got %b want %b", {hz.ForwardA_E, hz.ForwardB_E}, 4'b0010);
    end
    checks++;
    hz.Rd_M = 0;
    #1;
    if (hz.ForwardB_E !== 2'b01) begin errors++; $display("FAIL fwd_wb: got %b want %b", hz.ForwardB_E, 2'b01); end
    checks++;
    hz.Rd_M = 7; hz.Rs2_E = 0;
    #1;
    if (hz.ForwardB_E !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b want %b", hz.ForwardB_E, 2'b00); end
    checks++;
    hz.Rs1_E = 7; hz.RegWrite_M = 0;
    #1;
    if (hz.ForwardA_E !== 2'b01) begin errors++; $display("FAIL fwd_a_nowe: got %b want %b", hz.ForwardA_E, 2'b01); end
    checks++;
  endtask

  task automatic test_redirect();
    next_cycle();
    idle_inputs();
    hz.PCSrc_E = 1;
    #1;
    if (ctrl !== 6'b000011) begin errors++; $display("FAIL redir_c0: got %b want %b", ctrl, 6'b000011); end
    checks++;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      idle_inputs();
      #1;
      if (ctrl !== ((i < 3) ? 6'b000010 : 6'b000000)) begin
        errors++; $display("FAIL redir_c%0d: got %b want %b", i, ctrl, (i < 3) ? 6'b000010 : 6'b000000);
      end
      checks++;
    end
    if (hz.flush_cnt !== 32'(3 * PERF)) begin errors++; $display("FAIL redir_flush_cnt: got %0d want %0d", hz.flush_cnt, 3 * PERF); end
    checks++;
  endtask

  task automatic test_branch_vs_load();
    next_cycle();
    idle_inputs();
    hz.PCSrc_E = 1; hz.RegWrite_E = 1; hz.ResultSrc_E = 2'b01; hz.Rd_E = 9; hz.Rs2_D = 9;
    #1;
    if (ctrl !== 6'b000011) begin errors++; $display("FAIL br_over_lw: got %b want %b", ctrl, 6'b000011); end
    checks++;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      idle_inputs();
      #1;
      if (ctrl !== ((i < 3) ? 6'b000010 : 6'b000000)) begin
        errors++; $display("FAIL br_lw_tail%0d: got %b want %b", i, ctrl, (i < 3) ? 6'b000010 : 6'b000000);
      end
      checks++;
    end
  endtask

  task automatic test_mem_wait_redirect();
    next_cycle();
    idle_inputs();
    hz.PCSrc_E = 1;
    #1;
    if (ctrl !== 6'b000011) begin errors++; $display("FAIL mw_branch: got %b want %b", ctrl, 6'b000011); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle_inputs();
      hz.mem_busy = 1;
      #1;
      if (ctrl !== 6'b111100) begin errors++; $display("FAIL mw_freeze%0d: got %b want %b", i, ctrl, 6'b111100); end
      checks++;
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_inputs();
      #1;
      if (ctrl !== ((i < 2) ? 6'b000010 : 6'b000000)) begin
        errors++; $display("FAIL mw_resume%0d: got %b want %b", i, ctrl, (i < 2) ? 6'b000010 : 6'b000000);
      end
      checks++;
    end
    if (hz.wait_cnt !== 32'(4 * PERF)) begin errors++; $display("FAIL mw_wait_cnt: got %0d want %0d", hz.wait_cnt, 4 * PERF); end
    checks++;
    if (hz.flush_cnt !== 32'(9 * PERF)) begin errors++; $display("FAIL mw_flush_cnt: got %0d want %0d", hz.flush_cnt, 9 * PERF); end
    checks++;
  endtask

  task automatic test_mem_wait_release();
    // Branch and load are ignored while frozen, then honoured on release.
    next_cycle();
    idle_inputs();
    hz.mem_busy = 1; hz.PCSrc_E = 1; hz.RegWrite_E = 1; hz.ResultSrc_E = 2'b01; hz.Rd_E = 4; hz.Rs1_D = 4;
    #1;
    if (ctrl !== 6'b111100) begin errors++; $display("FAIL rel_freeze: got %b want %b", ctrl, 6'b111100); end
    checks++;
    next_cycle();
    hz.mem_busy = 0; hz.PCSrc_E = 0;
    #1;
    if (ctrl !== 6'b110001) begin errors++; $display("FAIL rel_lw: got %b want %b", ctrl, 6'b110001); end
    checks++;
  endtask

  task automatic test_reset_mid_wait();
    next_cycle();
    idle_inputs();
    hz.mem_busy = 1;
    #1;
    if (ctrl !== 6'b111100) begin errors++; $display("FAIL rst_pre: got %b want %b", ctrl, 6'b111100); end
    checks++;
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    if (ctrl !== 6'b000000) begin errors++; $display("FAIL rst_async_ctrl: got %b want %b", ctrl, 6'b000000); end
    checks++;
    if ({hz.stall_cnt, hz.flush_cnt, hz.wait_cnt} !== 96'd0) begin
      errors++; $display("FAIL rst_async_cnt: got %0d/%0d/%0d want 0/0/0", hz.stall_cnt, hz.flush_cnt, hz.wait_cnt);
    end
    checks++;
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    hz.PCSrc_E = 1;
    #1;
    if (ctrl !== 6'b000011) begin errors++; $display("FAIL rst_run_branch: got %b want %b", ctrl, 6'b000011); end
    checks++;
    // Reset mid-REDIRECT drops the remaining countdown.
    next_cycle();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    if (ctrl !== 6'b000000) begin errors++; $display("FAIL rst_redir_lost: got %b want %b", ctrl, 6'b000000); end
    checks++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_redirect();
    test_branch_vs_load();
    test_mem_wait_redirect();
    test_mem_wait_release();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
